ps2_rx_mux: RTL

Parametrised multi-channel PS/2 device-to-host receiver. It deserialises up to CHANNELS independent PS/2 ports, such as several keyboards and mice, into 8-bit scan/packet bytes and buffers each channel in its own FIFO. It merges the buffered bytes onto one valid/ready byte stream tagged with channel number and error flag. It sits between the board PS/2 pins and the keyboard/mouse decoders inside Top, and replaces single-port receive logic.

---
 rtl/ps2_rx_mux.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_mux.sv
// Multi-channel PS/2 device-to-host receiver: per-channel synchroniser, clock filter,
// frame FSM and FIFO, merged round-robin onto one tagged valid/ready byte stream.
module ps2_rx_mux #(
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned FILTER     = 8,
   parameter int unsigned TIMEOUT    = 50000,
   localparam int unsigned CW        = (CHANNELS == 1) ? 1 : $clog2(CHANNELS)
) (
   input  logic                CLK50MHZ,
   input  logic                RST,
   input  logic [CHANNELS-1:0] ps2c,
   input  logic [CHANNELS-1:0] ps2d,
   output logic [7:0]          data_o,
   output logic [CW-1:0]       chan_o,
   output logic                err_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [CHANNELS-1:0] overflow_o
);

   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned PW  = AW + 1;
   localparam int unsigned FCW = $clog2(FILTER + 1);
   localparam int unsigned TW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} rx_state_e;

   logic [CHANNELS-1:0][8:0] head_c;
   logic [CHANNELS-1:0]      nempty_c;
   logic [CHANNELS-1:0]      pop_c;

   genvar g;
   for (g = 0; g < CHANNELS; g++) begin : g_ch
      logic [1:0]     cs_q, cs_d, ds_q, ds_d;
      logic           fclk_q, fclk_d;
      logic [FCW-1:0] fcnt_q, fcnt_d;
      logic           fall_c;
      rx_state_e      st_q, st_d;
      logic [2:0]     bcnt_q, bcnt_d;
      logic [7:0]     sh_q, sh_d;
      logic           perr_q, perr_d;
      logic [TW-1:0]  tmo_q, tmo_d;
      logic           push_c;
      logic [8:0]     push_w_c;
      logic [8:0]     mem_q [FIFO_DEPTH];
      logic [8:0]     mem_d [FIFO_DEPTH];
      logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
      logic           ovf_q, ovf_d;
      logic           full_c, empty_c;

      assign cs_d = {cs_q[0], ps2c[g]};
      assign ds_d = {ds_q[0], ps2d[g]};

      // Filtered clock flips only after FILTER consecutive disagreeing samples
      always_comb begin
         fclk_d = fclk_q;
         fcnt_d = '0;
         fall_c = 1'b0;
         if (cs_q[1] != fclk_q) begin
            if (fcnt_q == FCW'(FILTER - 1)) begin
               fclk_d = cs_q[1];
               fall_c = fclk_q;
            end else begin
               fcnt_d = fcnt_q + FCW'(1);
            end
         end
      end

      always_comb begin
         st_d   = st_q;
         bcnt_d = bcnt_q;
         sh_d   = sh_q;
         perr_d = perr_q;
         tmo_d  = tmo_q;
         push_c = 1'b0;
         if (st_q != S_IDLE) tmo_d = fall_c ? '0 : tmo_q + TW'(1);
         if (st_q != S_IDLE && tmo_q == TW'(TIMEOUT)) begin
            st_d = S_IDLE;
         end else if (fall_c) begin
            case (st_q)
               S_IDLE: if (!ds_q[1]) begin
                  st_d   = S_DATA;
                  bcnt_d = '0;
                  tmo_d  = '0;
               end
               S_DATA: begin
                  sh_d   = {ds_q[1], sh_q[7:1]};
                  bcnt_d = bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) st_d = S_PAR;
               end
               S_PAR: begin
                  perr_d = ~(^{sh_q, ds_q[1]});
                  st_d   = S_STOP;
               end
               S_STOP: begin
                  push_c = 1'b1;
                  st_d   = S_IDLE;
               end
               default: st_d = S_IDLE;
            endcase
         end
      end

      assign push_w_c = {perr_q | ~ds_q[1], sh_q};
      assign empty_c  = (wp_q == rp_q);
      assign full_c   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);

      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
      always_comb begin
         mem_d = mem_q;
         wp_d  = wp_q;
         rp_d  = rp_q;
         ovf_d = ovf_q;
         if (pop_c[g]) rp_d = rp_q + PW'(1);
         if (push_c) begin
            if (!full_c || pop_c[g]) begin
               mem_d[wp_q[AW-1:0]] = push_w_c;
               wp_d = wp_q + PW'(1);
            end else begin
               ovf_d = 1'b1;
            end
         end
      end

      always_ff @(posedge CLK50MHZ or posedge RST) begin
         if (RST) begin
            cs_q   <= 2'b11;
            ds_q   <= 2'b11;
            fclk_q <= 1'b1;
            fcnt_q <= '0;
            st_q   <= S_IDLE;
            bcnt_q <= '0;
            sh_q   <= '0;
            perr_q <= 1'b0;
            tmo_q  <= '0;
            mem_q  <= '{default: '0};
            wp_q   <= '0;
            rp_q   <= '0;
            ovf_q  <= 1'b0;
         end else begin
            cs_q   <= cs_d;
            ds_q   <= ds_d;
            fclk_q <= fclk_d;
            fcnt_q <= fcnt_d;
            st_q   <= st_d;
            bcnt_q <= bcnt_d;
            sh_q   <= sh_d;
            perr_q <= perr_d;
            tmo_q  <= tmo_d;
            mem_q  <= mem_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            ovf_q  <= ovf_d;
         end
      end

      assign head_c[g]     = mem_q[rp_q[AW-1:0]];
      assign nempty_c[g]   = ~empty_c;
      assign overflow_o[g] = ovf_q;
   end

   logic [7:0]    data_q, data_d;
   logic [CW-1:0] chan_q, chan_d;
   logic          err_q, err_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] rr_q, rr_d;

   // Round-robin pick starting at rr_q; output register reloads when empty or consumed
   always_comb begin
      int unsigned idx;
      int unsigned sel;
      logic        found;
      data_d  = data_q;
      chan_d  = chan_q;
      err_d   = err_q;
      valid_d = valid_q;
      rr_d    = rr_q;
      pop_c   = '0;
      found   = 1'b0;
      sel     = 0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         idx = 32'(rr_q) + i;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         if (!found && nempty_c[CW'(idx)]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      if (!valid_q || ready_i) begin
         valid_d = found;
         if (found) begin
            pop_c[CW'(sel)] = 1'b1;
            {err_d, data_d} = head_c[CW'(sel)];
            chan_d          = CW'(sel);
            rr_d            = (sel == CHANNELS - 1) ? '0 : CW'(sel + 1);
         end
      end
   end

   always_ff @(posedge CLK50MHZ or posedge RST) begin
      if (RST) begin
         data_q  <= '0;
         chan_q  <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         rr_q    <= '0;
      end else begin
         data_q  <= data_d;
         chan_q  <= chan_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         rr_q    <= rr_d;
      end
   end

   assign data_o  = data_q;
   assign chan_o  = chan_q;
   assign err_o   = err_q;
   assign valid_o = valid_q;

endmodule
